// File: rtl/mem_array_loader_if.sv
// Byte-stream handshake bundle feeding mem_array_loader.
// A byte moves when in_valid && in_ready are both high at a rising clk edge.
interface mem_array_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    // Byte source side
    modport master (output in_valid, output in_data, input in_ready);
    // Loader side
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mem_array_loader.sv
// mem_array_loader: takes framed bytes (SYNC, N, N*4 data bytes LSB first),
// builds 32-bit words and writes them to processor data memory starting at
// BASE_ADDR. After a good frame it pulses cpu_start.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that
// must match before cpu_start is issued.
module mem_array_loader #(
    parameter int         ADDR_W    = 8,
    parameter int         BASE_ADDR = 40,
    parameter int         MAX_WORDS = 10,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_array_loader_if.slave     in_if,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [7:0] MAX_COUNT = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_FINISH
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    // State entered once all words are written (or straight after N=0)
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = S_CHECK;
`else
    localparam state_t END_STATE = S_FINISH;
`endif

    state_t              state_q, state_d;
    logic [7:0]          count_q, count_d;
    logic [7:0]          index_q, index_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         word_q, word_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_start_q, cpu_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                accept;
    logic [7:0]          index_inc;

    assign accept    = in_if.in_valid && in_ready_q;
    assign index_inc = index_q + 8'd1;

    // Next-state and next-output logic; every output is registered from its _d
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        index_d     = index_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept && in_if.in_data == SYNC_BYTE) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = in_if.in_data;
`endif
                    if (in_if.in_data > MAX_COUNT) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (in_if.in_data == 8'd0) begin
                        state_d = END_STATE;
                    end else begin
                        count_d    = in_if.in_data;
                        index_d    = 8'd0;
                        byte_cnt_d = 2'd0;
                        word_d     = 32'd0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[8*byte_cnt_q +: 8] = in_if.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_if.in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(index_q);
                        mem_wdata_d = word_d;
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                index_d = index_inc;
                if (index_inc == count_q) begin
                    state_d = END_STATE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (in_if.in_data == csum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_we_d    = (state_d == S_WRITE);
        cpu_start_d = (state_d == S_FINISH);
        if (state_d == S_FINISH) begin
            done_d = 1'b1;
        end
        in_ready_d  = !(state_d == S_WRITE || state_d == S_FINISH);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= 8'd0;
            index_q     <= 8'd0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 32'd0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_start_q <= cpu_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign cpu_start      = cpu_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: doc/mem_array_loader.md
Name: mem_array_loader

Overview:
- Writer-side companion to the sort processor's data memory: accepts a byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes each word into processor memory starting at word address BASE_ADDR, then pulses a start signal to the processor.
- Sits between the host/bench byte source and the data-memory write port of the processor + ALU top, replacing direct preloading of Mem[40..49].

Parameters:
- ADDR_W, 8, width of the memory word address.
- BASE_ADDR, 40, first word address written.
- MAX_WORDS, 10, largest legal word count; a count above this is a framing error.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can take a byte; a transfer occurs when in_valid && in_ready at a clk rising edge.
- mem_we  output  1  one-cycle write strobe.
- mem_addr  output  ADDR_W  word address, valid while mem_we=1.
- mem_wdata  output  32  word data, valid while mem_we=1.
- cpu_start  output  1  one-cycle pulse after a good frame.
- busy  output  1  frame in progress (state other than IDLE).
- done  output  1  sticky: last frame loaded OK.
- err  output  1  sticky: last frame rejected.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_start=0, busy=0, done=0, err=0; word index, byte counter and assembly register cleared.
- Frame format: SYNC_BYTE, count N (8-bit), then N×4 data bytes, least-significant byte first.
- IDLE: in_ready=1. Accepted bytes other than SYNC_BYTE are discarded. Accepting SYNC_BYTE clears done and err and moves to COUNT.
- COUNT: in_ready=1. On the accepted byte N:
  - N > MAX_WORDS: set err, go to IDLE.
  - N = 0: go to FINISH.
  - Otherwise: latch N, clear index and byte counter, go to DATA.
- DATA: in_ready=1. Each accepted byte shifts into bits [8k+7:8k] for byte k = 0..3. Acceptance of byte 3 moves to WRITE.
- WRITE: exactly one cycle; in_ready=0. mem_we=1, mem_addr=BASE_ADDR+index (truncated to ADDR_W, wraps), mem_wdata=assembled word. Then index+1:
  - If index+1 = N: go to FINISH.
  - Otherwise: go to DATA.
- Latency: last data byte accepted at edge t → mem_we high during cycle t+1.
- FINISH: one cycle; in_ready=0. cpu_start=1, done=1, then go to IDLE.
- mem_we and cpu_start are registered outputs; they are never high in the same cycle.
- Stalls: in_valid low in any state holds state and partial data indefinitely. No timeout.
- Reset mid-frame aborts immediately. Memory writes already issued are not undone, and no cpu_start is issued.
- A SYNC_BYTE appearing inside COUNT or DATA is treated as ordinary data; there is no resynchronisation.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or immediately after N=0), state CHECK with in_ready=1 accepts one byte.
  - The expected value is the XOR of N and all data bytes.
  - Match: go to FINISH.
  - Mismatch: set err, no cpu_start, go to IDLE. Words already written remain in memory.
- Undefined: no CHECK state; the frame ends after the last word as described above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles → all outputs at reset values, in_ready=1; bytes 0x00, 0x13 with valid high → no state change, busy=0.
- Nominal load: A5, 0A, then words 9,8,...,0 (e.g. 09 00 00 00 …) → ten mem_we pulses at addr 40..49 with data 9..0, each one cycle after the 4th byte; then cpu_start pulse, done=1. Run 1000 clocks of the processor → Mem[40..49]=0..9.
- Backpressure/stall: drop in_valid for 5 cycles between bytes 2 and 3 of word 0x11223344 → single write of 0x11223344 to addr 40, no extra strobes.
- Bad count: A5, 0B → err=1, no mem_we, no cpu_start, state IDLE. A following A5 clears err.
- Zero count and reset mid-frame: A5, 00 → cpu_start with no writes. A5, 02, four bytes, then rst_n low → one write at 40, no cpu_start, outputs back at reset values.
- LOADER_CHECKSUM_EN: A5, 01, 01 02 03 04, checksum 05 → write at 40 and cpu_start. The same frame with checksum 00 → write at 40, err=1, no cpu_start.
